// File: rtl/io_stream_pkg.sv
// Shared constants for the memory-mapped stream port: register offsets,
// STATUS/CTRL bit positions and the STATUS word packer.
package io_stream_pkg;

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_RXDATA = 2'd2,
    OFF_CTRL   = 2'd3
  } io_off_e;

  localparam int unsigned ST_COUNT_LSB = 0;
  localparam int unsigned ST_COUNT_W   = 4;
  localparam int unsigned ST_EMPTY     = 4;
  localparam int unsigned ST_FULL      = 5;
  localparam int unsigned ST_OVERFLOW  = 6;
  localparam int unsigned ST_RX_FULL   = 7;

  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  function automatic logic [31:0] pack_status(
    input logic [ST_COUNT_W-1:0] count,
    input logic                  empty,
    input logic                  full,
    input logic                  overflow,
    input logic                  rx_full
  );
    logic [31:0] s;
    s = '0;
    s[ST_COUNT_LSB +: ST_COUNT_W] = count;
    s[ST_EMPTY]    = empty;
    s[ST_FULL]     = full;
    s[ST_OVERFLOW] = overflow;
    s[ST_RX_FULL]  = rx_full;
    return s;
  endfunction

endpackage

// File: rtl/io_stream_port_if.sv
// Bus-side and stream-side signals of io_stream_port; slave is the
// peripheral view, master is the CPU/consumer/producer view.
interface io_stream_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  addr, wdata, we, re, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, wdata, we, re, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_stream_port_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally and
// reads as zero while empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_stream_port.sv
// Memory-mapped TX FIFO / RX holding register on the I/O half of the bus.
// Receive path is built only when IO_STREAM_RX_EN is defined.
module io_stream_port
  import io_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clock,
  input logic              resetn,
  io_stream_port_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  io_off_e         off;
  logic            sel;
  logic            wr_tx;
  logic            wr_ctrl;
  logic            flush;
  logic            clr_ovf;
  logic            pop;
  logic            push;
  logic            ovf_set;
  logic            overflow;
  logic [31:0]     head;
  logic [CW-1:0]   fifo_count;
  logic [3:0]      count4;
  logic            fifo_full;
  logic            fifo_empty;
  logic            rx_full_bit;
  logic [31:0]     rx_word;
  logic            unused_bits;

  assign sel     = bus.addr[7] & (bus.addr[6:4] == 3'b000);
  assign off     = io_off_e'(bus.addr[3:2]);
  assign wr_tx   = sel & bus.we & (off == OFF_TXDATA);
  assign wr_ctrl = sel & bus.we & (off == OFF_CTRL);
  assign flush   = wr_ctrl & bus.wdata[CTRL_FLUSH];
  assign clr_ovf = wr_ctrl & bus.wdata[CTRL_CLR_OVF];

  assign pop     = ~fifo_empty & bus.tx_ready;
  assign push    = wr_tx & (~fifo_full | pop);
  assign ovf_set = wr_tx & fifo_full & ~pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wdata  (bus.wdata),
    .rdata  (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.tx_data  = head;
  assign bus.tx_valid = ~fifo_empty;
  assign count4       = 4'(fifo_count);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef IO_STREAM_RX_EN
  logic        rx_full;
  logic [31:0] rx_hold;
  logic        rx_take;
  logic        rx_read;

  assign rx_take = bus.rx_valid & ~rx_full;
  assign rx_read = sel & bus.re & (off == OFF_RXDATA);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else if (rx_take) begin
      rx_full <= 1'b1;
      rx_hold <= bus.rx_data;
    end else if (rx_read) begin
      rx_full <= 1'b0;
    end
  end

  assign bus.rx_ready = ~rx_full;
  assign rx_full_bit  = rx_full;
  assign rx_word      = rx_hold;
  assign unused_bits  = ^{bus.addr[31:8], bus.addr[1:0]};
`else
  assign bus.rx_ready = 1'b0;
  assign rx_full_bit  = 1'b0;
  assign rx_word      = '0;
  assign unused_bits  = ^{bus.addr[31:8], bus.addr[1:0], bus.re,
                          bus.rx_data, bus.rx_valid};
`endif

  always_comb begin
    bus.rdata = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: bus.rdata = pack_status(count4, fifo_empty, fifo_full,
                                            overflow, rx_full_bit);
        OFF_RXDATA: bus.rdata = rx_word;
        default:    bus.rdata = '0;
      endcase
    end
  end

endmodule
